// File: rtl/nubus_master_arbiter_if.sv
// nubus_master_arbiter_if: requester-side and NuBus-master-side signals of the
// on-card arbiter. The master modport is the arbiter's view (it masters the
// CPU-bus port); the slave modport is the view of the surrounding logic
// (requesters plus the NuBus master port).
interface nubus_master_arbiter_if #(
    parameter int NREQ = 2
);
    // Requester side, slice i belongs to requester i
    logic [NREQ-1:0]      req_valid;
    logic [32*NREQ-1:0]   req_addr;
    logic [32*NREQ-1:0]   req_wdata;
    logic [4*NREQ-1:0]    req_write;
    logic [NREQ-1:0]      req_lock;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_error;
    logic [31:0]          req_rdata;

    // NuBus master CPU-bus port
    logic                 cpu_valid;
    logic [31:0]          cpu_addr;
    logic [31:0]          cpu_wdata;
    logic [3:0]           cpu_write;
    logic                 cpu_lock;
    logic                 cpu_ready;
    logic [31:0]          cpu_rdata;

    modport master (
        input  req_valid, req_addr, req_wdata, req_write, req_lock,
        output req_ready, req_error, req_rdata,
        output cpu_valid, cpu_addr, cpu_wdata, cpu_write, cpu_lock,
        input  cpu_ready, cpu_rdata
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_write, req_lock,
        input  req_ready, req_error, req_rdata,
        input  cpu_valid, cpu_addr, cpu_wdata, cpu_write, cpu_lock,
        output cpu_ready, cpu_rdata
    );
endinterface

// File: rtl/nubus_master_arbiter.sv
// nubus_master_arbiter: shares the single NuBus master CPU-bus port between
// NREQ on-card requesters. Round-robin arbitration in IDLE, the winner's
// request is registered onto cpu_* and held until cpu_ready, read data goes
// back to the winner only, and locked sequences keep ownership.
// FSM: IDLE -> WAIT -> DONE -> GAP -> IDLE (at most one transfer per 4 cycles).
// Optional feature: define NUBUS_ARB_WDT_EN to enable the WAIT-state watchdog
// (WDT_W-bit counter, aborts with req_error and read data 32'hFFFFFFFF).
module nubus_master_arbiter #(
    parameter int NREQ  = 2,
    parameter int WDT_W = 8
) (
    input  logic                   nub_clk,
    input  logic                   nub_reset,
    nubus_master_arbiter_if.master bus,
    output logic [1:0]             grant_id,
    output logic                   busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // One-hot vector selecting requester id
    function automatic logic [NREQ-1:0] onehot_of(input logic [1:0] id);
        logic [NREQ-1:0] v;
        v = '0;
        for (int k = 0; k < NREQ; k++) begin
            v[k] = (k == int'(id));
        end
        return v;
    endfunction

`ifdef NUBUS_ARB_WDT_EN
    // Terminal count is reached when the incremented value would hit 2^WDT_W-1
    localparam logic [WDT_W-1:0] WDT_TERM = WDT_W'((1 << WDT_W) - 2);
    localparam logic [WDT_W-1:0] WDT_ONE  = WDT_W'(1);
    logic [WDT_W-1:0] wdt_r, wdt_s;
`else
    // WDT_W only matters with the watchdog; the error tie-off is written in
    // terms of it so the parameter stays referenced in this build too.
    localparam logic ERR_TIE = 1'b0 & (WDT_W > 0);
`endif

    state_t          state_r, state_s;
    logic [1:0]      last_r, last_s;
    logic [1:0]      grant_r, grant_s;
    logic            lock_own_r, lock_own_s;
    logic            lock_r, lock_s;          // lock flag of the transfer in flight
    logic            cpu_valid_r, cpu_valid_s;
    logic [31:0]     cpu_addr_r, cpu_addr_s;
    logic [31:0]     cpu_wdata_r, cpu_wdata_s;
    logic [3:0]      cpu_write_r, cpu_write_s;
    logic            cpu_lock_r, cpu_lock_s;
    logic [NREQ-1:0] req_ready_r, req_ready_s;
    logic [NREQ-1:0] req_error_r, req_error_s;
    logic [31:0]     req_rdata_r, req_rdata_s;
    logic            busy_r, busy_s;

    // Arbitration results
    logic            own_valid_s;
    logic            win_found_s;
    logic [1:0]      win_id_s;
    logic [31:0]     win_addr_s;
    logic [31:0]     win_wdata_s;
    logic [3:0]      win_write_s;
    logic            win_lock_s;

    // Round-robin winner search (or lock owner only) and its request fields
    always_comb begin
        own_valid_s = 1'b0;
        win_found_s = 1'b0;
        win_id_s    = 2'd0;
        win_addr_s  = 32'd0;
        win_wdata_s = 32'd0;
        win_write_s = 4'd0;
        win_lock_s  = 1'b0;

        for (int k = 0; k < NREQ; k++) begin
            own_valid_s = own_valid_s | (bus.req_valid[k] & (k == int'(grant_r)));
        end

        if (lock_own_r) begin
            win_found_s = own_valid_s;
            win_id_s    = grant_r;
        end else begin
            // Scan offsets 0..NREQ-1 starting one past the last owner
            for (int off = 0; off < NREQ; off++) begin
                for (int j = 0; j < NREQ; j++) begin
                    if (!win_found_s && bus.req_valid[j] &&
                        (j == ((int'(last_r) + 1 + off) % NREQ))) begin
                        win_found_s = 1'b1;
                        win_id_s    = 2'(j);
                    end else begin
                        win_found_s = win_found_s;
                        win_id_s    = win_id_s;
                    end
                end
            end
        end

        for (int k = 0; k < NREQ; k++) begin
            if (k == int'(win_id_s)) begin
                win_addr_s  = bus.req_addr[k*32 +: 32];
                win_wdata_s = bus.req_wdata[k*32 +: 32];
                win_write_s = bus.req_write[k*4 +: 4];
                win_lock_s  = bus.req_lock[k];
            end else begin
                win_addr_s  = win_addr_s;
                win_wdata_s = win_wdata_s;
                win_write_s = win_write_s;
                win_lock_s  = win_lock_s;
            end
        end
    end

    // Next-state and next-output logic of the transfer FSM
    always_comb begin
        state_s     = state_r;
        last_s      = last_r;
        grant_s     = grant_r;
        lock_own_s  = lock_own_r;
        lock_s      = lock_r;
        cpu_valid_s = cpu_valid_r;
        cpu_addr_s  = cpu_addr_r;
        cpu_wdata_s = cpu_wdata_r;
        cpu_write_s = cpu_write_r;
        cpu_lock_s  = cpu_lock_r;
        req_ready_s = '0;
`ifdef NUBUS_ARB_WDT_EN
        req_error_s = '0;
        wdt_s       = wdt_r;
`else
        req_error_s = {NREQ{ERR_TIE}};
`endif
        req_rdata_s = req_rdata_r;

        case (state_r)
            ST_IDLE: begin
                if (lock_own_r && !own_valid_s) begin
                    // Owner let go of a locked sequence: release, arbitrate next cycle
                    lock_own_s = 1'b0;
                    cpu_lock_s = 1'b0;
                end else if (win_found_s) begin
                    state_s     = ST_WAIT;
                    last_s      = win_id_s;
                    grant_s     = win_id_s;
                    lock_s      = win_lock_s;
                    cpu_valid_s = 1'b1;
                    cpu_addr_s  = win_addr_s;
                    cpu_wdata_s = win_wdata_s;
                    cpu_write_s = win_write_s;
                    cpu_lock_s  = win_lock_s;
`ifdef NUBUS_ARB_WDT_EN
                    wdt_s       = '0;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus.cpu_ready) begin
                    state_s     = ST_DONE;
                    cpu_valid_s = 1'b0;
                    req_rdata_s = bus.cpu_rdata;
                    req_ready_s = onehot_of(grant_r);
                end
`ifdef NUBUS_ARB_WDT_EN
                else if (wdt_r == WDT_TERM) begin
                    // Watchdog abort: error completion, ownership is not kept
                    state_s     = ST_DONE;
                    cpu_valid_s = 1'b0;
                    req_rdata_s = 32'hFFFF_FFFF;
                    req_ready_s = onehot_of(grant_r);
                    req_error_s = onehot_of(grant_r);
                    lock_s      = 1'b0;
                    cpu_lock_s  = 1'b0;
                end else begin
                    wdt_s = wdt_r + WDT_ONE;
                end
`else
                else begin
                    state_s = ST_WAIT;
                end
`endif
            end
            ST_DONE: begin
                state_s    = ST_GAP;
                lock_own_s = lock_r;
                cpu_lock_s = lock_r;
            end
            ST_GAP: begin
                // Masks the still-visible acknowledge of the finished transfer
                state_s = ST_IDLE;
            end
            default: begin
                state_s     = ST_IDLE;
                cpu_valid_s = 1'b0;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge nub_clk) begin
        if (nub_reset) begin
            state_r     <= ST_IDLE;
            last_r      <= 2'(NREQ - 1);
            grant_r     <= 2'd0;
            lock_own_r  <= 1'b0;
            lock_r      <= 1'b0;
            cpu_valid_r <= 1'b0;
            cpu_addr_r  <= 32'd0;
            cpu_wdata_r <= 32'd0;
            cpu_write_r <= 4'd0;
            cpu_lock_r  <= 1'b0;
            req_ready_r <= '0;
            req_error_r <= '0;
            req_rdata_r <= 32'd0;
            busy_r      <= 1'b0;
`ifdef NUBUS_ARB_WDT_EN
            wdt_r       <= '0;
`endif
        end else begin
            state_r     <= state_s;
            last_r      <= last_s;
            grant_r     <= grant_s;
            lock_own_r  <= lock_own_s;
            lock_r      <= lock_s;
            cpu_valid_r <= cpu_valid_s;
            cpu_addr_r  <= cpu_addr_s;
            cpu_wdata_r <= cpu_wdata_s;
            cpu_write_r <= cpu_write_s;
            cpu_lock_r  <= cpu_lock_s;
            req_ready_r <= req_ready_s;
            req_error_r <= req_error_s;
            req_rdata_r <= req_rdata_s;
            busy_r      <= busy_s;
`ifdef NUBUS_ARB_WDT_EN
            wdt_r       <= wdt_s;
`endif
        end
    end

    assign bus.cpu_valid = cpu_valid_r;
    assign bus.cpu_addr  = cpu_addr_r;
    assign bus.cpu_wdata = cpu_wdata_r;
    assign bus.cpu_write = cpu_write_r;
    assign bus.cpu_lock  = cpu_lock_r;
    assign bus.req_ready = req_ready_r;
    assign bus.req_error = req_error_r;
    assign bus.req_rdata = req_rdata_r;
    assign grant_id      = grant_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_nubus_master_arbiter.sv
// tb_nubus_master_arbiter: directed self-checking bench for the NuBus master
// arbiter (NREQ=2, WDT_W=4). Inputs are driven and outputs sampled on the
// falling clock edge; a small responder plays the NuBus master port.
module tb_nubus_master_arbiter;

    logic        nub_clk = 1'b0;
    logic        nub_reset;
    logic [1:0]  grant_id;
    logic        busy;

    int          checks = 0;
    int          errors = 0;

    // Responder controls
    logic        ack_en;
    logic        ack_force;
    int          ack_delay;
    logic [31:0] ack_data;
    int          ack_cnt = 0;

    nubus_master_arbiter_if #(.NREQ(2)) bus ();

    nubus_master_arbiter #(.NREQ(2), .WDT_W(4)) dut (
        .nub_clk   (nub_clk),
        .nub_reset (nub_reset),
        .bus       (bus),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 nub_clk = ~nub_clk;

    // NuBus master port model: acks ack_delay falling edges after cpu_valid is seen
    always @(negedge nub_clk) begin
        if (ack_force) begin
            bus.cpu_ready <= 1'b1;
            bus.cpu_rdata <= ack_data;
            ack_cnt       <= 0;
        end else if (ack_en && bus.cpu_valid === 1'b1) begin
            if (ack_cnt >= ack_delay) begin
                bus.cpu_ready <= 1'b1;
                bus.cpu_rdata <= ack_data;
                ack_cnt       <= 0;
            end else begin
                bus.cpu_ready <= 1'b0;
                ack_cnt       <= ack_cnt + 1;
            end
        end else begin
            bus.cpu_ready <= 1'b0;
            ack_cnt       <= 0;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Wait (bounded) until the arbiter is back in IDLE
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge nub_clk);
            n++;
        end
        check_eq("idle_reached", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not end, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] exp_seq [4];
        int exp_id, npulse, last_cyc, item, lock_chk, c_hit;

        exp_seq = '{2'b10, 2'b10, 2'b10, 2'b01};

        nub_reset     = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_addr  = {32'h2000_0000, 32'h1000_0000};
        bus.req_wdata = 64'd0;
        bus.req_write = 8'd0;
        bus.req_lock  = 2'b00;
        ack_en        = 1'b1;
        ack_force     = 1'b0;
        ack_delay     = 0;
        ack_data      = 32'd0;

        // 1. Reset held 3 cycles with both requesting
        for (int i = 0; i < 3; i++) begin
            @(negedge nub_clk);
            check_eq("rst_cpu_valid", {63'd0, bus.cpu_valid}, 64'd0);
            check_eq("rst_req_ready", {62'd0, bus.req_ready}, 64'd0);
            check_eq("rst_grant",     {62'd0, grant_id},      64'd0);
            check_eq("rst_busy",      {63'd0, busy},          64'd0);
            check_eq("rst_cpu_addr",  {32'd0, bus.cpu_addr},  64'd0);
            check_eq("rst_rdata",     {32'd0, bus.req_rdata}, 64'd0);
        end
        nub_reset = 1'b0;
        @(negedge nub_clk);
        check_eq("first_grant",     {62'd0, grant_id},      64'd0);
        check_eq("first_cpu_valid", {63'd0, bus.cpu_valid}, 64'd1);
        check_eq("first_cpu_addr",  {32'd0, bus.cpu_addr},  64'h1000_0000);
        bus.req_valid = 2'b00;
        wait_idle();

        // 2. Single read by requester 0, ack three cycles after cpu_valid
        ack_delay = 2;
        ack_data  = 32'hDEAD_BEEF;
        bus.req_addr[31:0]  = 32'hF900_0010;
        bus.req_write[3:0]  = 4'd0;
        bus.req_valid       = 2'b01;
        @(negedge nub_clk);
        check_eq("rd_latency",   {63'd0, bus.cpu_valid}, 64'd1);
        check_eq("rd_addr",      {32'd0, bus.cpu_addr},  64'hF900_0010);
        check_eq("rd_write",     {60'd0, bus.cpu_write}, 64'd0);
        @(negedge nub_clk);
        check_eq("rd_addr_hold", {32'd0, bus.cpu_addr},  64'hF900_0010);
        bus.req_addr[31:0] = 32'h0BAD_0BAD;
        @(negedge nub_clk);
        check_eq("rd_addr_frozen", {32'd0, bus.cpu_addr}, 64'hF900_0010);
        check_eq("rd_no_early_rdy", {62'd0, bus.req_ready}, 64'd0);
        @(negedge nub_clk);
        check_eq("rd_ready",     {62'd0, bus.req_ready}, 64'd1);
        check_eq("rd_error",     {62'd0, bus.req_error}, 64'd0);
        check_eq("rd_rdata",     {32'd0, bus.req_rdata}, 64'hDEAD_BEEF);
        check_eq("rd_valid_drop", {63'd0, bus.cpu_valid}, 64'd0);
        bus.req_valid = 2'b00;
        @(negedge nub_clk);
        check_eq("rd_ready_pulse", {62'd0, bus.req_ready}, 64'd0);
        check_eq("rd_gap_busy",    {63'd0, busy},          64'd1);
        check_eq("rd_gap_valid",   {63'd0, bus.cpu_valid}, 64'd0);
        @(negedge nub_clk);
        check_eq("rd_back_idle",   {63'd0, busy},          64'd0);

        // 3. Both requesting continuously, immediate ack: strict alternation, period 4
        ack_delay     = 0;
        bus.req_valid = 2'b11;
        exp_id   = 1;
        npulse   = 0;
        last_cyc = 0;
        for (int c = 1; c <= 40 && npulse < 6; c++) begin
            @(negedge nub_clk);
            if (bus.req_ready != 2'b00) begin
                check_eq("rr_ready", {62'd0, bus.req_ready}, (exp_id == 0) ? 64'd1 : 64'd2);
                check_eq("rr_grant", {62'd0, grant_id}, 64'(exp_id));
                if (npulse > 0) begin
                    check_eq("rr_period", 64'(c - last_cyc), 64'd4);
                end
                last_cyc = c;
                npulse++;
                exp_id = 1 - exp_id;
                if (npulse == 6) begin
                    bus.req_valid = 2'b00;
                end
            end
        end
        check_eq("rr_count", 64'(npulse), 64'd6);
        wait_idle();

        // 4. Requester 1 locked sequence (lock,lock,unlock) with requester 0 pending
        item = 0;
        bus.req_addr  = {32'hF100_0000, 32'hF200_0000};
        bus.req_wdata = {32'hCAFE_0000, 32'h0000_0000};
        bus.req_write = {4'hF, 4'h0};
        bus.req_lock  = 2'b10;
        bus.req_valid = 2'b11;
        @(negedge nub_clk);
        check_eq("lk_first_grant", {62'd0, grant_id},      64'd1);
        check_eq("lk_first_write", {60'd0, bus.cpu_write}, 64'hF);
        check_eq("lk_first_wdata", {32'd0, bus.cpu_wdata}, 64'hCAFE_0000);
        check_eq("lk_first_lock",  {63'd0, bus.cpu_lock},  64'd1);
        npulse   = 0;
        lock_chk = 0;
        for (int c = 0; c < 60 && npulse < 4; c++) begin
            @(negedge nub_clk);
            if (lock_chk == 1) begin
                check_eq("lk_hold",    {63'd0, bus.cpu_lock}, 64'd1);
            end else if (lock_chk == 2) begin
                check_eq("lk_release", {63'd0, bus.cpu_lock}, 64'd0);
            end
            lock_chk = 0;
            if (bus.req_ready != 2'b00) begin
                check_eq("lk_order", {62'd0, bus.req_ready}, {62'd0, exp_seq[npulse]});
                if (npulse < 2) begin
                    lock_chk = 1;
                end else if (npulse == 2) begin
                    lock_chk = 2;
                end
                if (bus.req_ready[1]) begin
                    item++;
                    bus.req_addr[63:32]  = 32'hF100_0000 + 32'(item * 4);
                    bus.req_wdata[63:32] = 32'hCAFE_0000 + 32'(item);
                    bus.req_lock[1]      = (item < 2);
                    if (item == 3) begin
                        bus.req_valid[1] = 1'b0;
                    end
                end
                if (bus.req_ready[0]) begin
                    bus.req_valid[0] = 1'b0;
                end
                npulse++;
            end
        end
        check_eq("lk_count", 64'(npulse), 64'd4);
        wait_idle();

        // 5. No acknowledge from the NuBus master
        ack_en        = 1'b0;
        bus.req_lock  = 2'b00;
        bus.req_valid = 2'b01;
`ifdef NUBUS_ARB_WDT_EN
        c_hit = 0;
        for (int c = 1; c <= 30 && c_hit == 0; c++) begin
            @(negedge nub_clk);
            if (bus.req_ready != 2'b00) begin
                c_hit = c;
                check_eq("wdt_ready", {62'd0, bus.req_ready}, 64'd1);
                check_eq("wdt_error", {62'd0, bus.req_error}, 64'd1);
                check_eq("wdt_rdata", {32'd0, bus.req_rdata}, 64'hFFFF_FFFF);
            end
        end
        check_eq("wdt_cycles", 64'(c_hit), 64'd16);
        bus.req_valid = 2'b00;
        wait_idle();
        bus.req_valid = 2'b01;
        repeat (3) @(negedge nub_clk);
`else
        c_hit = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge nub_clk);
            if (bus.req_ready != 2'b00) begin
                c_hit++;
            end
        end
        check_eq("nowdt_no_ready",  64'(c_hit), 64'd0);
        check_eq("nowdt_cpu_valid", {63'd0, bus.cpu_valid}, 64'd1);
        check_eq("nowdt_busy",      {63'd0, busy},          64'd1);
`endif

        // 6. Reset in WAIT, acknowledge arriving right after it
        check_eq("rst6_in_wait", {63'd0, bus.cpu_valid}, 64'd1);
        nub_reset     = 1'b1;
        bus.req_valid = 2'b00;
        ack_data      = 32'h1234_5678;
        ack_force     = 1'b1;
        @(negedge nub_clk);
        check_eq("rst6_valid", {63'd0, bus.cpu_valid}, 64'd0);
        check_eq("rst6_busy",  {63'd0, busy},          64'd0);
        nub_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge nub_clk);
            check_eq("rst6_no_ready", {62'd0, bus.req_ready}, 64'd0);
            check_eq("rst6_idle",     {63'd0, bus.cpu_valid}, 64'd0);
        end
        check_eq("rst6_rdata", {32'd0, bus.req_rdata}, 64'd0);
        ack_force = 1'b0;

        // 7. After reset, requester 0 wins first again
        ack_en        = 1'b1;
        ack_delay     = 0;
        ack_data      = 32'h0000_5A5A;
        bus.req_valid = 2'b11;
        @(negedge nub_clk);
        check_eq("post_rst_grant", {62'd0, grant_id},      64'd0);
        check_eq("post_rst_valid", {63'd0, bus.cpu_valid}, 64'd1);
        bus.req_valid = 2'b00;
        @(negedge nub_clk);
        check_eq("post_rst_ready", {62'd0, bus.req_ready}, 64'd1);
        check_eq("post_rst_rdata", {32'd0, bus.req_rdata}, 64'h0000_5A5A);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
